// File: rtl/code_seq_pkg.sv
// Shared types and defaults for the code sequencer and its storage.
// Sizes here must agree between the sequencer, its interface and the storage.
package code_seq_pkg;

    localparam int CODE_SIZE_DEF     = 12;
    localparam int MAX_CODE_LINE_DEF = 100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REWIND = 2'd2,
        RUN    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/code_sequencer_if.sv
// Bundle of host, consumer and storage-facing signals of the code sequencer.
// slave is the sequencer's view, master the host/consumer/storage side.
interface code_sequencer_if #(
    parameter int code_size = code_seq_pkg::CODE_SIZE_DEF
);
    logic                 load_start;
    logic                 load_valid;
    logic [code_size-1:0] load_data;
    logic                 load_last;
    logic                 load_ready;
    logic                 load_done;
    logic                 load_err;
    logic                 run_start;
    logic                 run_abort;
    logic                 run_done;
    logic                 run_err;
    logic                 exec_valid;
    logic                 exec_ready;
    logic [code_size-1:0] exec_code;
    logic [31:0]          exec_index;
    logic [31:0]          prog_len;
    logic                 busy;
    logic                 st_is_write;
    logic [31:0]          st_write_line;
    logic [code_size-1:0] st_write_data;
    logic                 st_active;
    logic                 st_reset;
    logic [code_size-1:0] st_code;
    logic [31:0]          st_code_index;

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  run_start, run_abort, exec_ready, st_code, st_code_index,
        output load_ready, load_done, load_err, run_done, run_err,
        output exec_valid, exec_code, exec_index, prog_len, busy,
        output st_is_write, st_write_line, st_write_data, st_active, st_reset
    );

    modport master (
        output load_start, load_valid, load_data, load_last,
        output run_start, run_abort, exec_ready, st_code, st_code_index,
        input  load_ready, load_done, load_err, run_done, run_err,
        input  exec_valid, exec_code, exec_index, prog_len, busy,
        input  st_is_write, st_write_line, st_write_data, st_active, st_reset
    );

endinterface

// File: rtl/code_storage.sv
// Program storage: synchronous write port plus a read pointer that rewinds on
// reset_i and steps forward on active_i; the word at the pointer is read combinationally.
module code_storage #(
    parameter int code_size     = code_seq_pkg::CODE_SIZE_DEF,
    parameter int max_code_line = code_seq_pkg::MAX_CODE_LINE_DEF
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 is_write_i,
    input  logic [31:0]          write_line_i,
    input  logic [code_size-1:0] write_data_i,
    input  logic                 active_i,
    output logic [code_size-1:0] code_o,
    output logic [31:0]          code_index_o
);

    logic [code_size-1:0] mem_q [max_code_line];
    logic [31:0]          code_line_q;
    logic [31:0]          code_line_d;

    always_comb begin
        code_line_d = code_line_q;
        if (reset_i) begin
            code_line_d = '0;
        end else if (active_i && (code_line_q < 32'(max_code_line - 1))) begin
            code_line_d = code_line_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        code_line_q <= code_line_d;
        if (is_write_i && (write_line_i < 32'(max_code_line))) begin
            mem_q[write_line_i] <= write_data_i;
        end
    end

    // The pointer never exceeds max_code_line-1, so the read index is always in range.
    assign code_o       = mem_q[code_line_q];
    assign code_index_o = code_line_q;

endmodule

// File: rtl/code_sequencer.sv
// Loads a program into code storage and replays it to a consumer under valid/ready.
//   state  | meaning
//   IDLE   | waiting for load_start or run_start
//   LOAD   | accepting program words, writing storage line wr_ptr
//   REWIND | one cycle holding storage reset so its read pointer returns to line 0
//   RUN    | presenting storage words until the last one is accepted or aborted
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int code_size     = CODE_SIZE_DEF,
    parameter int max_code_line = MAX_CODE_LINE_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    code_sequencer_if.slave          bus
);

    seq_state_e state_q, state_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] prog_len_q, prog_len_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
    logic        run_done_q, run_done_d;
    logic        run_err_q, run_err_d;

    logic [code_size-1:0] load_word;
    logic                 load_xfer;
    logic                 last_line;

    assign load_word = bus.load_data;
    assign last_line = (bus.st_code_index == (prog_len_q - 32'd1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            prog_len_q  <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            run_done_q  <= 1'b0;
            run_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            run_done_q  <= run_done_d;
            run_err_q   <= run_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        prog_len_d  = prog_len_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        run_done_d  = 1'b0;
        run_err_d   = 1'b0;
        load_xfer   = 1'b0;

        bus.load_ready    = 1'b0;
        bus.st_is_write   = 1'b0;
        bus.st_write_line = '0;
        bus.st_write_data = '0;
        bus.st_active     = 1'b0;
        bus.exec_valid    = 1'b0;
        bus.exec_code     = '0;
        bus.exec_index    = '0;

        // While reset is held every output is quiet except the storage reset.
        bus.st_reset  = !reset || (state_q == REWIND);
        bus.busy      = reset && (state_q != IDLE);
        bus.prog_len  = reset ? prog_len_q : 32'd0;
        bus.load_done = reset && load_done_q;
        bus.load_err  = reset && load_err_q;
        bus.run_done  = reset && run_done_q;
        bus.run_err   = reset && run_err_q;

        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_start) begin
                        state_d  = LOAD;
                        wr_ptr_d = '0;
                    end else if (bus.run_start) begin
                        if (prog_len_q != 32'd0) state_d = REWIND;
                        else                     run_err_d = 1'b1;
                    end
                end
                LOAD: begin
                    bus.load_ready    = 1'b1;
                    load_xfer         = bus.load_valid;
                    bus.st_is_write   = load_xfer;
                    bus.st_write_line = wr_ptr_q;
                    bus.st_write_data = load_word;
                    if (load_xfer) begin
                        wr_ptr_d = wr_ptr_q + 32'd1;
                        if (bus.load_last) begin
                            state_d     = IDLE;
                            prog_len_d  = wr_ptr_q + 32'd1;
                            load_done_d = 1'b1;
                        end else if (wr_ptr_q == 32'(max_code_line - 1)) begin
                            state_d     = IDLE;
                            prog_len_d  = 32'(max_code_line);
                            load_done_d = 1'b1;
                            load_err_d  = 1'b1;
                        end
                    end
                end
                REWIND: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.run_abort) begin
                        state_d    = IDLE;
                        run_done_d = 1'b1;
                    end else begin
                        bus.exec_valid = 1'b1;
                        bus.exec_code  = bus.st_code;
                        bus.exec_index = bus.st_code_index;
                        // The final word is not stepped past so the pointer rests on it.
                        if (bus.exec_ready) begin
                            if (last_line) begin
                                state_d    = IDLE;
                                run_done_d = 1'b1;
                            end else begin
                                bus.st_active = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer driving a real code_storage.
module tb_code_sequencer;
    import code_seq_pkg::*;

    localparam int CS = 12;
    localparam int ML = 100;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    code_sequencer_if #(.code_size(CS)) bus();

    code_sequencer #(.code_size(CS), .max_code_line(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    code_storage #(.code_size(CS), .max_code_line(ML)) store (
        .clk          (clk),
        .reset_i      (bus.st_reset),
        .is_write_i   (bus.st_is_write),
        .write_line_i (bus.st_write_line),
        .write_data_i (bus.st_write_data),
        .active_i     (bus.st_active),
        .code_o       (bus.st_code),
        .code_index_o (bus.st_code_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] exp_code [5];
        logic [31:0] exp_idx  [5];
        logic        exp_act  [5];
        logic        rdy_pat  [5];

        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.run_start  = 1'b0;
        bus.run_abort  = 1'b0;
        bus.exec_ready = 1'b0;

        step();
        step();
        chk("rst_st_reset", 32'(bus.st_reset), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_prog_len", bus.prog_len, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_release_st_reset", 32'(bus.st_reset), 32'd0);
        step();

        // Empty program: run_start reports an error and never leaves IDLE.
        bus.run_start = 1'b1;
        step();
        bus.run_start = 1'b0;
        #1;
        chk("empty_run_err", 32'(bus.run_err), 32'd1);
        chk("empty_busy", 32'(bus.busy), 32'd0);
        chk("empty_st_active", 32'(bus.st_active), 32'd0);
        step();
        chk("empty_run_err_clear", 32'(bus.run_err), 32'd0);
        chk("empty_busy2", 32'(bus.busy), 32'd0);

        // Three-word load.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 12'(32'h101 * (i + 1));
            bus.load_last  = (i == 2);
            #1;
            chk("ld3_ready", 32'(bus.load_ready), 32'd1);
            chk("ld3_is_write", 32'(bus.st_is_write), 32'd1);
            chk("ld3_line", bus.st_write_line, 32'(i));
            chk("ld3_data", 32'(bus.st_write_data), 32'h101 * (i + 1));
            chk("ld3_prog_len_hold", bus.prog_len, 32'd0);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        #1;
        chk("ld3_done", 32'(bus.load_done), 32'd1);
        chk("ld3_err", 32'(bus.load_err), 32'd0);
        chk("ld3_prog_len", bus.prog_len, 32'd3);
        chk("ld3_busy", 32'(bus.busy), 32'd0);
        step();
        chk("ld3_done_clear", 32'(bus.load_done), 32'd0);

        // Full-rate run.
        bus.exec_ready = 1'b1;
        bus.run_start  = 1'b1;
        step();
        bus.run_start = 1'b0;
        #1;
        chk("rew_busy", 32'(bus.busy), 32'd1);
        chk("rew_st_reset", 32'(bus.st_reset), 32'd1);
        chk("rew_exec_valid", 32'(bus.exec_valid), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("run3_valid", 32'(bus.exec_valid), 32'd1);
            chk("run3_code", 32'(bus.exec_code), 32'h101 * (i + 1));
            chk("run3_index", bus.exec_index, 32'(i));
            chk("run3_active", 32'(bus.st_active), (i < 2) ? 32'd1 : 32'd0);
            step();
        end
        chk("run3_done", 32'(bus.run_done), 32'd1);
        chk("run3_idle", 32'(bus.busy), 32'd0);
        step();
        chk("run3_done_clear", 32'(bus.run_done), 32'd0);

        // Stalling consumer: ready 1,0,0,1,1.
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_idx  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
        exp_code = '{12'h101, 12'h202, 12'h202, 12'h202, 12'h303};
        exp_act  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.run_start = 1'b1;
        step();
        bus.run_start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.exec_ready = rdy_pat[i];
            #1;
            chk("stall_index", bus.exec_index, exp_idx[i]);
            chk("stall_code", 32'(bus.exec_code), 32'(exp_code[i]));
            chk("stall_active", 32'(bus.st_active), 32'(exp_act[i]));
            step();
        end
        chk("stall_done", 32'(bus.run_done), 32'd1);
        step();

        // Five-word program, abort on second word, then rerun from line 0.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 12'(32'h101 * (i + 1));
            bus.load_last  = (i == 4);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        #1;
        chk("ld5_prog_len", bus.prog_len, 32'd5);
        bus.exec_ready = 1'b1;
        bus.run_start  = 1'b1;
        step();
        bus.run_start = 1'b0;
        step();
        chk("ab_first_index", bus.exec_index, 32'd0);
        step();
        bus.run_abort = 1'b1;
        #1;
        chk("ab_exec_valid", 32'(bus.exec_valid), 32'd0);
        chk("ab_st_active", 32'(bus.st_active), 32'd0);
        step();
        bus.run_abort = 1'b0;
        #1;
        chk("ab_run_done", 32'(bus.run_done), 32'd1);
        chk("ab_busy", 32'(bus.busy), 32'd0);
        bus.run_start = 1'b1;
        step();
        bus.run_start = 1'b0;
        step();
        chk("rerun_index", bus.exec_index, 32'd0);
        chk("rerun_code", 32'(bus.exec_code), 32'h101);
        for (int i = 0; i < 4; i++) step();
        chk("rerun_last_index", bus.exec_index, 32'd4);
        chk("rerun_last_code", 32'(bus.exec_code), 32'h505);
        step();
        chk("rerun_done", 32'(bus.run_done), 32'd1);
        step();

        // Capacity overflow: 102 words offered without load_last.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b0;
        for (int i = 0; i < ML; i++) begin
            bus.load_data = 12'(i + 32'h400);
            if (i == ML - 1) begin
                #1;
                chk("cap_ready_last", 32'(bus.load_ready), 32'd1);
                chk("cap_line_last", bus.st_write_line, 32'd99);
            end
            step();
        end
        bus.load_data = 12'h7AA;
        #1;
        chk("cap_done", 32'(bus.load_done), 32'd1);
        chk("cap_err", 32'(bus.load_err), 32'd1);
        chk("cap_prog_len", bus.prog_len, 32'd100);
        chk("cap_ready_drop", 32'(bus.load_ready), 32'd0);
        chk("cap_no_write", 32'(bus.st_is_write), 32'd0);
        step();
        bus.load_data = 12'h7BB;
        #1;
        chk("cap_done_clear", 32'(bus.load_done), 32'd0);
        chk("cap_ready_drop2", 32'(bus.load_ready), 32'd0);
        step();
        bus.load_valid = 1'b0;
        bus.exec_ready = 1'b1;
        bus.run_start  = 1'b1;
        step();
        bus.run_start = 1'b0;
        step();
        for (int i = 0; i < ML - 1; i++) step();
        chk("cap_run_last_index", bus.exec_index, 32'd99);
        chk("cap_run_last_code", 32'(bus.exec_code), 32'h463);
        chk("cap_run_last_active", 32'(bus.st_active), 32'd0);
        step();
        chk("cap_run_done", 32'(bus.run_done), 32'd1);
        step();

        // Reset pulse during a load.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 12'(32'h0A0 + i);
            step();
        end
        bus.load_data = 12'h0A2;
        reset = 1'b0;
        #1;
        chk("mid_rst_no_write", 32'(bus.st_is_write), 32'd0);
        chk("mid_rst_st_reset", 32'(bus.st_reset), 32'd1);
        step();
        reset = 1'b1;
        bus.load_valid = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_prog_len", bus.prog_len, 32'd0);
        chk("mid_rst_no_done", 32'(bus.load_done), 32'd0);
        step();
        chk("mid_rst_no_done2", 32'(bus.load_done), 32'd0);

        // Simultaneous load_start and run_start: load wins.
        bus.load_start = 1'b1;
        bus.run_start  = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        #1;
        chk("both_busy", 32'(bus.busy), 32'd1);
        chk("both_load_ready", 32'(bus.load_ready), 32'd1);
        chk("both_no_run_err", 32'(bus.run_err), 32'd0);
        bus.load_valid = 1'b1;
        bus.load_data  = 12'h0F1;
        bus.load_last  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        #1;
        chk("both_prog_len", bus.prog_len, 32'd1);
        chk("both_done", 32'(bus.load_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
Controller that owns the code_storage instance. It loads a program over a valid/ready stream into storage lines 0..N-1 and records the program length N. On command it rewinds storage to line 0 and issues code words to a downstream consumer under a valid/ready handshake, advancing storage only on accepted transfers. It sits between the host/loader and the execution datapath and is the only driver of the storage's write, active and reset inputs.

Parameters:
code_size, 12, width of one code word (matches storage)
max_code_line, 100, program capacity in words (lines 0..max_code_line-1 are used)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
load_start  in  1  begin program load (honoured in IDLE only)
load_valid  in  1  load word valid
load_data  in  code_size  load word
load_last  in  1  marks final word of program
load_ready  out  1  block accepts load word
load_done  out  1  one-cycle pulse, load finished
load_err  out  1  qualifies load_done: capacity hit before load_last
run_start  in  1  begin execution (honoured in IDLE only)
run_abort  in  1  stop execution immediately
run_done  out  1  one-cycle pulse, last word accepted or abort
run_err  out  1  one-cycle pulse, run_start with prog_len==0
exec_valid  out  1  exec_code valid
exec_ready  in  1  consumer accepts word
exec_code  out  code_size  current code word
exec_index  out  32  line index of exec_code
prog_len  out  32  words in stored program
busy  out  1  state != IDLE
st_is_write  out  1  to storage is_write
st_write_line  out  32  to storage write_line
st_write_data  out  code_size  to storage write_data
st_active  out  1  to storage active
st_reset  out  1  to storage reset (active-high)
st_code  in  code_size  from storage code
st_code_index  in  32  from storage code_index

Behaviour:
- States: IDLE, LOAD, REWIND, RUN. Reset: state IDLE, wr_ptr 0, prog_len 0, all outputs 0 except st_reset=1 while reset low.
- st_reset = !reset || state==REWIND (combinational).
- IDLE: load_start -> LOAD, wr_ptr<=0. Else run_start: prog_len>0 -> REWIND; prog_len==0 -> run_err pulse next cycle, stay IDLE. load_start and run_start together: load wins, run ignored.
- LOAD: load_ready=1. Transfer = load_valid&&load_ready. st_is_write=transfer, st_write_line=wr_ptr, st_write_data=load_data (combinational, zero-latency write at same edge). On transfer, wr_ptr<=wr_ptr+1.
- LOAD exit: transfer with load_last -> IDLE, prog_len<=wr_ptr+1, load_done pulse next cycle, load_err=0. Transfer at wr_ptr==max_code_line-1 without load_last -> IDLE, prog_len<=max_code_line, load_done and load_err pulse next cycle. prog_len keeps its old value until exit.
- REWIND: exactly one cycle; storage code_line goes to 0 at that edge; -> RUN.
- RUN: exec_valid = !run_abort; exec_code=st_code, exec_index=st_code_index (combinational pass-through). Accept = exec_valid&&exec_ready.
- st_active = accept && st_code_index != prog_len-1; storage advances exactly once per accepted non-final word, never on stall.
- Accept with st_code_index==prog_len-1 -> IDLE, run_done pulse next cycle; storage index stays at prog_len-1.
- run_abort in RUN -> IDLE, no transfer that cycle, run_done pulse next cycle. run_abort outside RUN ignored.
- load_start/run_start outside IDLE ignored; no queuing.
- Reset low mid-LOAD or mid-RUN: next state IDLE, prog_len 0, no pulses.

Decomposition:
- Package code_seq_pkg: state enum (IDLE, LOAD, REWIND, RUN), constant for code_size default.
- Single module, no sub-modules. Testbench instantiates code_sequencer plus real code_storage.

Test Plan:
- Load 3 words 0x101,0x202,0x303 (last on third), exec_ready=1, run -> load_done, load_err=0, prog_len=3; REWIND 1 cycle; exec_code 0x101,0x202,0x303 on consecutive cycles, exec_index 0,1,2; run_done 1 cycle after third.
- Run with exec_ready toggling 1,0,0,1,1 -> each word presented until accepted; st_active high only on accept cycles; no word skipped or repeated.
- Load max_code_line+2 words with no load_last -> load_ready drops after 100 accepted, load_done and load_err pulse, prog_len=100, words 100..101 not accepted.
- run_start after reset (prog_len=0) -> run_err pulse, busy stays 0, st_active never asserted.
- Assert run_abort on second word of 5-word program -> exec_valid=0 that cycle, run_done next cycle, IDLE; rerun restarts at index 0.
- reset=0 for one cycle mid-LOAD after 2 words -> IDLE, prog_len=0, no load_done; load_start and run_start same cycle in IDLE -> LOAD entered.
